// File: rtl/exc_ctrl.sv
// ---------------------------------------------------------------------------
// exc_ctrl -- precise exception / interrupt / ERET sequencer.
//
// A retiring instruction (inst_valid) may carry exception causes, or may be
// interrupted by a pending, enabled interrupt. In IDLE the highest-priority
// event is captured. The controller then asks the pipeline to flush, writes
// the CP0 exception state for one cycle (or clears EXL for ERET), and steers
// fetch to the handler (or to EPC for ERET) for one cycle.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   inst_valid, in_delay_slot retiring instruction present / it sits in a delay slot
//   pc                        PC of the retiring instruction
//   iaddr_err .. daddr_err    cause inputs; mem_wen selects store/load address error
//   mem_addr                  data address of the faulting access
//   epc_in                    current CP0 EPC (ERET target)
//   int_enable                IE && !EXL
//   irq, irq_mask             interrupt lines and their mask
//   flush_req / flush_ack     pipeline flush handshake
//   busy                      stall request while a sequence is in flight
//   redirect_valid/_pc        one-cycle fetch redirect
//   cp0_*                     one-cycle CP0 update strobe and data
//   exc_count                 saturating count of committed non-ERET events
// ---------------------------------------------------------------------------
module exc_ctrl #(
  parameter int          N_IRQ      = 8,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  input  logic              in_delay_slot,
  input  logic [31:0]       pc,
  input  logic              iaddr_err,
  input  logic              syscall,
  input  logic              brk,
  input  logic              ri,
  input  logic              cpu_unusable,
  input  logic              ovf,
  input  logic              eret,
  input  logic              daddr_err,
  input  logic              mem_wen,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       epc_in,
  input  logic              int_enable,
  input  logic [N_IRQ-1:0]  irq,
  input  logic [N_IRQ-1:0]  irq_mask,
  output logic              flush_req,
  input  logic              flush_ack,
  output logic              busy,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              cp0_we,
  output logic              cp0_exl_clr,
  output logic [4:0]        cp0_code,
  output logic [31:0]       cp0_epc,
  output logic              cp0_bd,
  output logic [31:0]       cp0_badvaddr,
  output logic              cp0_badvaddr_we,
  output logic [CNT_W-1:0]  exc_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_COMMIT,
    S_REDIRECT
  } state_t;

  state_t            state_q, state_d;
  logic              irq_pend_q;
  logic [4:0]        code_q;
  logic              is_eret_q;
  logic [31:0]       epc_q;
  logic              bd_q;
  logic [31:0]       badvaddr_q;
  logic              badvaddr_valid_q;
  logic [31:0]       target_q;
  logic [CNT_W-1:0]  cnt_q;

  // Decoded event of the retiring instruction, in priority order.
  logic              ev_hit;
  logic [4:0]        ev_code;
  logic              ev_eret;
  logic [31:0]       ev_badvaddr;
  logic              ev_badvaddr_valid;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    ev_hit            = 1'b0;
    ev_code           = 5'h00;
    ev_eret           = 1'b0;
    ev_badvaddr       = 32'h0;
    ev_badvaddr_valid = 1'b0;
    if (inst_valid) begin
      ev_hit = 1'b1;
      if (int_enable && irq_pend_q) begin
        ev_code = 5'h00;
      end else if (iaddr_err) begin
        ev_code           = 5'h04;
        ev_badvaddr       = pc;
        ev_badvaddr_valid = 1'b1;
      end else if (syscall) begin
        ev_code = 5'h08;
      end else if (brk) begin
        ev_code = 5'h09;
      end else if (ri) begin
        ev_code = 5'h0A;
      end else if (cpu_unusable) begin
        ev_code = 5'h0B;
      end else if (ovf) begin
        ev_code = 5'h0C;
      end else if (eret) begin
        ev_eret = 1'b1;
      end else if (daddr_err) begin
        ev_code           = mem_wen ? 5'h05 : 5'h04;
        ev_badvaddr       = mem_addr;
        ev_badvaddr_valid = 1'b1;
      end else begin
        ev_hit = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the capture registers are cleared on reset as well so no stale
      // event data survives an aborted sequence.
      state_q          <= S_IDLE;
      irq_pend_q       <= 1'b0;
      code_q           <= 5'h00;
      is_eret_q        <= 1'b0;
      epc_q            <= 32'h0;
      bd_q             <= 1'b0;
      badvaddr_q       <= 32'h0;
      badvaddr_valid_q <= 1'b0;
      target_q         <= 32'h0;
      cnt_q            <= '0;
    end else begin
      state_q    <= state_d;
      irq_pend_q <= |(irq & irq_mask);
      if (state_q == S_IDLE && ev_hit) begin
        code_q           <= ev_code;
        is_eret_q        <= ev_eret;
        // Delay-slot instructions restart at the branch (wraps modulo 2^32).
        epc_q            <= in_delay_slot ? pc - 32'd4 : pc;
        bd_q             <= in_delay_slot;
        badvaddr_q       <= ev_badvaddr;
        badvaddr_valid_q <= ev_badvaddr_valid;
        target_q         <= ev_eret ? epc_in : EXC_VECTOR;
      end
      // Count on the FLUSH->COMMIT transition so the new value is visible
      // during COMMIT; saturate at all-ones.
      if (state_q == S_FLUSH && flush_ack && !is_eret_q && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next state and outputs. Outputs are forced to their reset values
  // combinationally while rst is high so they are clean from the first cycle.
  always_comb begin
    state_d         = state_q;
    flush_req       = 1'b0;
    busy            = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = EXC_VECTOR;
    cp0_we          = 1'b0;
    cp0_exl_clr     = 1'b0;
    cp0_code        = 5'h00;
    cp0_epc         = 32'h0;
    cp0_bd          = 1'b0;
    cp0_badvaddr    = 32'h0;
    cp0_badvaddr_we = 1'b0;
    exc_count       = rst ? '0 : cnt_q;

    case (state_q)
      S_IDLE:     if (ev_hit) state_d = S_FLUSH;
      S_FLUSH:    if (flush_ack) state_d = S_COMMIT;
      S_COMMIT:   state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    if (!rst) begin
      case (state_q)
        S_FLUSH: begin
          busy      = 1'b1;
          flush_req = 1'b1;
        end
        S_COMMIT: begin
          busy            = 1'b1;
          cp0_code        = code_q;
          cp0_epc         = epc_q;
          cp0_bd          = bd_q;
          cp0_badvaddr    = badvaddr_q;
          cp0_we          = !is_eret_q;
          cp0_exl_clr     = is_eret_q;
          cp0_badvaddr_we = badvaddr_valid_q && !is_eret_q;
        end
        S_REDIRECT: begin
          busy           = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = target_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exc_ctrl -- scoreboard bench for exc_ctrl (CNT_W=8 to reach saturation).
// Stimulus issues one event at a time from IDLE, computes the expected CP0
// update and redirect from the priority rules, and queues it; a monitor on the
// falling edge pops and compares whenever the DUT strobes COMMIT or REDIRECT.
// ---------------------------------------------------------------------------
module tb_exc_ctrl;

  localparam logic [31:0] EXC_VEC = 32'hBFC00380;
  localparam int          CMAX    = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0, in_delay_slot = 1'b0;
  logic [31:0] pc = 32'h0, mem_addr = 32'h0, epc_in = 32'h0;
  logic        iaddr_err = 1'b0, syscall = 1'b0, brk = 1'b0, ri = 1'b0;
  logic        cpu_unusable = 1'b0, ovf = 1'b0, eret = 1'b0, daddr_err = 1'b0;
  logic        mem_wen = 1'b0, int_enable = 1'b0, flush_ack = 1'b0;
  logic [7:0]  irq = 8'h0, irq_mask = 8'h0;
  logic        flush_req, busy, redirect_valid, cp0_we, cp0_exl_clr, cp0_bd;
  logic        cp0_badvaddr_we;
  logic [31:0] redirect_pc, cp0_epc, cp0_badvaddr;
  logic [4:0]  cp0_code;
  logic [7:0]  exc_count;

  exc_ctrl #(.N_IRQ(8), .EXC_VECTOR(EXC_VEC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .in_delay_slot(in_delay_slot),
    .pc(pc), .iaddr_err(iaddr_err), .syscall(syscall), .brk(brk), .ri(ri),
    .cpu_unusable(cpu_unusable), .ovf(ovf), .eret(eret), .daddr_err(daddr_err),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .epc_in(epc_in), .int_enable(int_enable),
    .irq(irq), .irq_mask(irq_mask), .flush_req(flush_req), .flush_ack(flush_ack),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .cp0_we(cp0_we), .cp0_exl_clr(cp0_exl_clr), .cp0_code(cp0_code),
    .cp0_epc(cp0_epc), .cp0_bd(cp0_bd), .cp0_badvaddr(cp0_badvaddr),
    .cp0_badvaddr_we(cp0_badvaddr_we), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        bd;
    logic [31:0] pc, mem_addr, epc_in;
    logic        iaddr, sys, brk, ri, cu, ovf, eret, daddr, mem_wen, int_en;
    logic [7:0]  irq, mask;
  } ev_t;

  typedef struct {
    logic        valid;
    logic [4:0]  code;
    logic        is_eret;
    logic [31:0] epc;
    logic        bd;
    logic [31:0] bva;
    logic        bva_v;
    logic [31:0] target;
    int          cnt;
    int          commit_cyc;
    int          flush_n;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } redir_t;

  exp_t   commit_q[$];
  redir_t redir_q[$];
  int     abort_q[$];

  int n_pass = 0, n_total = 0;
  int cnt_m = 0;
  int flush_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the first cause that applies, in architectural priority.
  function automatic exp_t model(input ev_t e, input logic pend);
    exp_t       r;
    logic       hit[9];
    logic [4:0] codes[9];
    int         idx;
    hit   = '{e.int_en && pend, e.iaddr, e.sys, e.brk, e.ri, e.cu, e.ovf, e.eret, e.daddr};
    codes = '{5'h00, 5'h04, 5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h00,
              (e.mem_wen ? 5'h05 : 5'h04)};
    idx = -1;
    for (int i = 0; i < 9; i++) if (hit[i] && idx < 0) idx = i;
    r.valid      = (idx >= 0);
    r.code       = (idx >= 0) ? codes[idx] : 5'h00;
    r.is_eret    = (idx == 7);
    r.epc        = e.bd ? e.pc - 32'd4 : e.pc;
    r.bd         = e.bd;
    r.bva_v      = (idx == 1) || (idx == 8);
    r.bva        = (idx == 1) ? e.pc : e.mem_addr;
    r.target     = r.is_eret ? e.epc_in : EXC_VEC;
    r.cnt        = 0;
    r.commit_cyc = 0;
    r.flush_n    = 0;
    return r;
  endfunction

  function automatic ev_t zero_ev();
    ev_t e;
    e.bd = 0; e.pc = 0; e.mem_addr = 0; e.epc_in = 0;
    e.iaddr = 0; e.sys = 0; e.brk = 0; e.ri = 0; e.cu = 0; e.ovf = 0;
    e.eret = 0; e.daddr = 0; e.mem_wen = 0; e.int_en = 0; e.irq = 0; e.mask = 0;
    return e;
  endfunction

  function automatic ev_t rand_ev();
    ev_t e;
    e.bd = 1'($urandom_range(0, 1));
    e.pc = $urandom; e.mem_addr = $urandom; e.epc_in = $urandom;
    e.iaddr = ($urandom_range(0, 7) == 0); e.sys = ($urandom_range(0, 7) == 0);
    e.brk = ($urandom_range(0, 7) == 0);   e.ri = ($urandom_range(0, 7) == 0);
    e.cu = ($urandom_range(0, 7) == 0);    e.ovf = ($urandom_range(0, 7) == 0);
    e.eret = ($urandom_range(0, 7) == 0);  e.daddr = ($urandom_range(0, 5) == 0);
    e.mem_wen = 1'($urandom_range(0, 1));  e.int_en = 1'($urandom_range(0, 1));
    e.irq = 8'($urandom); e.mask = 8'($urandom_range(0, 3) == 0 ? $urandom : 0);
    return e;
  endfunction

  task automatic drive_idle_bits();
    inst_valid = 0; iaddr_err = 0; syscall = 0; brk = 0; ri = 0;
    cpu_unusable = 0; ovf = 0; eret = 0; daddr_err = 0;
  endtask

  // Activity while busy; all of it must be ignored by the DUT.
  task automatic drive_garbage();
    inst_valid = 1; syscall = 1'($urandom_range(0, 1)); iaddr_err = 1'($urandom_range(0, 1));
    brk = 1'($urandom_range(0, 1)); ri = 1'($urandom_range(0, 1)); eret = 1'($urandom_range(0, 1));
    cpu_unusable = 1'($urandom_range(0, 1)); ovf = 1'($urandom_range(0, 1));
    daddr_err = 1'($urandom_range(0, 1)); pc = $urandom; irq = 8'($urandom);
  endtask

  // One transaction: a prep cycle to settle irq_pend, the event cycle, then
  // d cycles of flush_ack low before the acknowledge, then COMMIT/REDIRECT.
  task automatic txn(input ev_t e, input int d);
    exp_t x;
    @(posedge clk); #1;
    drive_idle_bits();
    irq = e.irq; irq_mask = e.mask; flush_ack = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    inst_valid = 1; in_delay_slot = e.bd; pc = e.pc; mem_addr = e.mem_addr;
    epc_in = e.epc_in; iaddr_err = e.iaddr; syscall = e.sys; brk = e.brk; ri = e.ri;
    cpu_unusable = e.cu; ovf = e.ovf; eret = e.eret; daddr_err = e.daddr;
    mem_wen = e.mem_wen; int_enable = e.int_en; flush_ack = 1'($urandom_range(0, 1));
    x = model(e, |(e.irq & e.mask));
    if (!x.valid) return;
    if (!x.is_eret && cnt_m < CMAX) cnt_m++;
    x.cnt        = cnt_m;
    x.commit_cyc = cyc + 2 + d;
    x.flush_n    = d + 1;
    commit_q.push_back(x);
    for (int j = 0; j <= d; j++) begin
      @(posedge clk); #1;
      drive_garbage();
      flush_ack = (j == d);
    end
    repeat (2) begin
      @(posedge clk); #1;
      drive_garbage();
      flush_ack = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; drive_idle_bits();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    cnt_m = 0;
  endtask

  // Monitor: reset values, COMMIT and REDIRECT strobes against the queues.
  always @(negedge clk) begin
    exp_t   e;
    redir_t r;
    if (rst) begin
      check("rst_strobes", 32'({flush_req, busy, redirect_valid, cp0_we, cp0_exl_clr,
                                cp0_bd, cp0_badvaddr_we}), 32'h0);
      check("rst_data", cp0_epc | cp0_badvaddr | 32'(cp0_code), 32'h0);
      check("rst_exc_count", 32'(exc_count), 32'h0);
      check("rst_redirect_pc", redirect_pc, EXC_VEC);
      if (abort_q.size() > 0) check("abort_flush_cycles", flush_cnt, abort_q.pop_front());
      flush_cnt = 0;
    end else begin
      if (flush_req) flush_cnt++;
      if (cp0_we || cp0_exl_clr) begin
        if (commit_q.size() == 0) begin
          check("unexpected_commit", 32'(cp0_we), 32'(cp0_exl_clr ^ 1'b1) ^ 32'h1 ^ 32'(cp0_we));
        end else begin
          e = commit_q.pop_front();
          check("commit_cycle", cyc, e.commit_cyc);
          check("flush_cycles", flush_cnt, e.flush_n);
          check("cp0_we", 32'(cp0_we), 32'(!e.is_eret));
          check("cp0_exl_clr", 32'(cp0_exl_clr), 32'(e.is_eret));
          if (!e.is_eret) check("cp0_code", 32'(cp0_code), 32'(e.code));
          check("cp0_epc", cp0_epc, e.epc);
          check("cp0_bd", 32'(cp0_bd), 32'(e.bd));
          check("cp0_badvaddr_we", 32'(cp0_badvaddr_we), 32'(e.bva_v && !e.is_eret));
          if (e.bva_v) check("cp0_badvaddr", cp0_badvaddr, e.bva);
          check("exc_count", 32'(exc_count), e.cnt);
          r.pc  = e.target;
          r.cyc = e.commit_cyc + 1;
          redir_q.push_back(r);
        end
        flush_cnt = 0;
      end
      if (redirect_valid) begin
        if (redir_q.size() == 0) begin
          check("unexpected_redirect", redirect_pc, ~redirect_pc);
        end else begin
          r = redir_q.pop_front();
          check("redirect_cycle", cyc, r.cyc);
          check("redirect_pc", redirect_pc, r.pc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t e;
    do_reset();

    // Syscall at a plain PC.
    e = zero_ev(); e.sys = 1; e.pc = 32'h80001000; txn(e, 0);
    // Store address error in a delay slot.
    e = zero_ev(); e.daddr = 1; e.mem_wen = 1; e.mem_addr = 32'h3; e.bd = 1;
    e.pc = 32'h80000010; txn(e, 1);
    // Interrupt beats overflow; with the line masked, overflow is taken.
    e = zero_ev(); e.irq = 8'h08; e.mask = 8'h08; e.int_en = 1; e.ovf = 1; e.pc = 32'h80000100;
    txn(e, 0);
    e.mask = 8'h00; txn(e, 2);
    // ERET: target from epc_in, count unchanged.
    e = zero_ev(); e.eret = 1; e.epc_in = 32'h80002000; e.pc = 32'h80000200; txn(e, 0);
    // EPC wrap at pc=0 in a delay slot; instruction address error; load error.
    e = zero_ev(); e.sys = 1; e.pc = 32'h0; e.bd = 1; txn(e, 0);
    e = zero_ev(); e.iaddr = 1; e.pc = 32'h80000401; e.daddr = 1; txn(e, 3);
    e = zero_ev(); e.daddr = 1; e.mem_wen = 0; e.mem_addr = 32'h80000007; txn(e, 0);

    // Abort: flush never acknowledged, reset after five FLUSH cycles.
    @(posedge clk); #1;
    drive_idle_bits(); irq_mask = 0;
    @(posedge clk); #1;
    inst_valid = 1; syscall = 1; flush_ack = 0;
    repeat (5) begin
      @(posedge clk); #1;
      drive_idle_bits(); flush_ack = 0;
    end
    abort_q.push_back(5);
    @(posedge clk); #1;
    rst = 1; cnt_m = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < 300; i++) txn(rand_ev(), $urandom_range(0, 4));

    // Saturation: 257+ back-to-back syscalls from a fresh counter.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      e = zero_ev(); e.sys = 1; e.pc = $urandom; e.bd = 1'($urandom_range(0, 1));
      txn(e, 0);
    end

    repeat (8) @(posedge clk);
    #1;
    check("commit_q_drained", commit_q.size(), 0);
    check("redir_q_drained", redir_q.size(), 0);
    check("abort_q_drained", abort_q.size(), 0);
    check("final_exc_count", 32'(exc_count), CMAX);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
